// File: rtl/var_8_3_to_1.sv
// Registered 3-to-1 byte selector for the SPI transmit path.
// Ports: clk, rst_n, in1..in3, load, next, auto_en, sel -> out, idx, last.
module var_8_3_to_1 #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] IDLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             load,
    input  logic             next,
    input  logic             auto_en,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       idx,
    output logic             last
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] s3_q, s3_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic [1:0]       code;

    always_comb begin
        s1_d  = s1_q;
        s2_d  = s2_q;
        s3_d  = s3_q;
        ptr_d = ptr_q;
        if (load) begin
            s1_d  = in1;
            s2_d  = in2;
            s3_d  = in3;
            ptr_d = 2'd0;
        end else if (auto_en && next) begin
            // Three-byte frame: wrap after byte 2
            ptr_d = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        end
    end

    // Selection uses next-state values so a load is visible on the same edge
    always_comb begin
        code   = auto_en ? ptr_d : sel;
        out_d  = IDLE_VAL;
        idx_d  = code;
        last_d = auto_en && (ptr_d == 2'd2);
        unique case (code)
            2'd0:    out_d = s1_d;
            2'd1:    out_d = s2_d;
            2'd2:    out_d = s3_d;
            default: out_d = IDLE_VAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            ptr_q  <= 2'd0;
            out_q  <= '0;
            idx_q  <= 2'd0;
            last_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            ptr_q  <= ptr_d;
            out_q  <= out_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign last = last_q;

endmodule

// File: tb/tb_var_8_3_to_1.sv
// Testbench for var_8_3_to_1: frame-level model plus directed vectors.
module tb_var_8_3_to_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in1, in2, in3;
    logic       load, next, auto_en;
    logic [1:0] sel;
    logic [7:0] out;
    logic [1:0] idx;
    logic       last;

    int checks   = 0;
    int failures = 0;

    var_8_3_to_1 dut (
        .clk(clk), .rst_n(rst_n),
        .in1(in1), .in2(in2), .in3(in3),
        .load(load), .next(next), .auto_en(auto_en), .sel(sel),
        .out(out), .idx(idx), .last(last)
    );

    always #5 clk = ~clk;

    // Frame model: snapshot array plus byte position within the frame
    int   m_snap [3] = '{0, 0, 0};
    int   m_pos      = 0;
    int   e_out      = 0;
    int   e_idx      = 0;
    bit   e_last     = 0;

    always @(posedge clk or negedge rst_n) begin
        int code;
        if (!rst_n) begin
            m_snap = '{0, 0, 0};
            m_pos  = 0;
            e_out  = 0;
            e_idx  = 0;
            e_last = 0;
        end else begin
            if (load) begin
                m_snap[0] = in1;
                m_snap[1] = in2;
                m_snap[2] = in3;
                m_pos     = 0;
            end else if (auto_en && next) begin
                m_pos = (m_pos + 1) % 3;
            end
            code   = auto_en ? m_pos : int'(sel);
            e_idx  = code;
            e_out  = (code == 3) ? 0 : m_snap[code];
            e_last = auto_en && (m_pos == 2);
        end
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("model_out",  int'(out),  e_out);
        check("model_idx",  int'(idx),  e_idx);
        check("model_last", int'(last), int'(e_last));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b1;
        in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        load = 0; next = 0; auto_en = 0; sel = 2'd0;
        #1 rst_n = 1'b0;

        // 1: reset hold
        repeat (8) begin
            step();
            check("rst_out", int'(out), 0);
            check("rst_idx", int'(idx), 0);
            check("rst_last", int'(last), 0);
        end
        rst_n = 1'b1;

        // 2: manual select
        in1 = 8'hA5; in2 = 8'h3C; in3 = 8'hF0;
        load = 1; sel = 2'd0;
        step();
        load = 0;
        check("man0_out", int'(out), 'hA5);
        check("man0_idx", int'(idx), 0);
        sel = 2'd1; step();
        check("man1_out", int'(out), 'h3C);
        check("man1_idx", int'(idx), 1);
        sel = 2'd2; step();
        check("man2_out", int'(out), 'hF0);
        check("man2_idx", int'(idx), 2);
        sel = 2'd3; step();
        check("man3_out", int'(out), 'h00);
        check("man3_idx", int'(idx), 3);

        // 3: auto round robin
        in1 = 8'h11; in2 = 8'h22; in3 = 8'h33;
        auto_en = 1; load = 1;
        step();
        load = 0;
        check("rr0_out", int'(out), 'h11);
        check("rr0_last", int'(last), 0);
        next = 1;
        step(); check("rr1_out", int'(out), 'h22);
        check("rr1_last", int'(last), 0);
        step(); check("rr2_out", int'(out), 'h33);
        check("rr2_last", int'(last), 1);
        step(); check("rr3_out", int'(out), 'h11);
        check("rr3_last", int'(last), 0);
        step(); check("rr4_out", int'(out), 'h22);
        next = 0;

        // 4: snapshot coherence
        auto_en = 0; sel = 2'd0;
        step(); check("hold0_out", int'(out), 'h11);
        in1 = 8'hFF;
        step(); check("hold1_out", int'(out), 'h11);
        load = 1;
        step(); check("reload_out", int'(out), 'hFF);
        load = 0;

        // 5: load beats next
        auto_en = 1; next = 1;
        step(); check("p1_out", int'(out), 'h22);
        in1 = 8'h5A; load = 1;
        step();
        check("ldnx_out", int'(out), 'h5A);
        check("ldnx_idx", int'(idx), 0);
        load = 0; next = 0;

        // 6: async reset mid-frame
        next = 1;
        step(); step();
        check("pre_rst_last", int'(last), 1);
        next = 0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_out", int'(out), 0);
        check("arst_idx", int'(idx), 0);
        check("arst_last", int'(last), 0);
        step();
        rst_n = 1'b1;
        next = 1;
        repeat (3) begin
            step();
            check("post_rst_out", int'(out), 0);
        end
        next = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/var_8_3_to_1.md
Name: var_8_3_to_1

Overview:
- Registered 3-to-1 byte selector for the SPI transmit path.
- Captures a coherent snapshot of three 8-bit variables (in1, in2, in3) and presents one of them on an 8-bit output.
- The output byte is chosen either by an explicit select or by an internal round-robin pointer that steps through the three bytes of an SPI frame.
- Sits between the data-source registers and the SPI shift-register loader.

Parameters:
- WIDTH, 8, bit width of each input variable and of out.
- IDLE_VAL, 8'h00, value driven on out for an invalid select code.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in1  input  WIDTH  variable 1 (frame byte 0).
- in2  input  WIDTH  variable 2 (frame byte 1).
- in3  input  WIDTH  variable 3 (frame byte 2).
- load  input  1  snapshot strobe: capture in1..in3 and reset the pointer.
- next  input  1  advance strobe for the round-robin pointer (auto mode only).
- auto_en  input  1  1 = pointer selects the byte; 0 = sel selects the byte.
- sel  input  2  manual select: 0 = in1, 1 = in2, 2 = in3, 3 = IDLE_VAL.
- out  output  WIDTH  selected byte, registered.
- idx  output  2  index of the byte currently on out (0..2; 3 when out = IDLE_VAL in manual mode).
- last  output  1  high while out holds snapshot byte 2 in auto mode.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, independent of clk):
  - snapshots s1, s2, s3 = 0.
  - pointer ptr = 0.
  - out = 0, idx = 0, last = 0.
- Reset release: the first active edge is the first rising clk edge with rst_n high.
- Snapshot capture:
  - On a clock edge with load = 1: s1 <= in1, s2 <= in2, s3 <= in3, ptr <= 0.
  - Without load, the snapshots hold; later input changes do not affect out.
- Pointer:
  - In auto mode, on an edge with next = 1 and load = 0: ptr advances 0 -> 1 -> 2 -> 0 (wraps).
  - next is ignored when auto_en = 0; ptr holds.
  - load and next on the same edge: load wins, ptr = 0.
- Selection code:
  - auto_en = 1: code = ptr.
  - auto_en = 0: code = sel.
  - The code is evaluated from the next-state snapshot and pointer values.
- Output update: out, idx and last are registered and update on every clock edge:
  - Code 0 -> out <= s1, idx <= 0.
  - Code 1 -> out <= s2, idx <= 1.
  - Code 2 -> out <= s3, idx <= 2.
  - Code 3 -> out <= IDLE_VAL, idx <= 3.
  - last <= auto_en AND (ptr_next == 2).
- Latency:
  - load at edge N: captured values are visible on out after edge N (same edge, through the next-state path).
  - Select, pointer and mode changes also appear on out after the next edge.
- Mode switch (auto_en toggled):
  - Does not modify ptr or the snapshots.
  - out follows the new source from the next edge.
- Width handling: straight pass-through; no arithmetic or truncation.
- Glitch behaviour: out is driven only from flops; no combinational path from inputs to out.
- Reset mid-frame: pointer and snapshots return to 0; the next frame needs a new load.

Test Plan:
1. Reset, all inputs 8'h00, hold 8 cycles -> out = 8'h00, idx = 0, last = 0 throughout.
2. in1 = 8'hA5, in2 = 8'h3C, in3 = 8'hF0, pulse load, auto_en = 0, sel stepped 0, 1, 2, 3 -> out A5, 3C, F0, 00 one cycle after each sel change; idx 0, 1, 2, 3.
3. Auto mode after load of 11/22/33, pulse next each cycle 4 times -> out 11, 22, 33, 11, 22; last high only while out = 33.
4. After load, change in1 to 8'hFF without load -> out still shows old s1 value; pulse load -> out = FF next cycle.
5. load and next asserted together with ptr = 1 -> ptr = 0, out = new in1.
6. Assert rst_n low asynchronously mid-frame with ptr = 2 -> out, idx, last drop to 0 immediately; after release, next without load outputs 00, 00, 00.
